// File: rtl/dab_mod_sequencer_if.sv
// Controller/modulator-facing bundle of the DAB modulation sequencer:
// requested targets and period trigger in, applied modulation and gating out.
interface dab_mod_sequencer_if #(
    parameter int W = 9
);
    logic                req_valid;
    logic signed [W-1:0] tau1_req;
    logic signed [W-1:0] tau2_req;
    logic signed [W-1:0] phi_req;
    logic                trigger;
    logic signed [W-1:0] tau1;
    logic signed [W-1:0] tau2;
    logic signed [W-1:0] phi;
    logic                gate_en;
    logic                upd;

    modport master (
        output req_valid, tau1_req, tau2_req, phi_req, trigger,
        input  tau1, tau2, phi, gate_en, upd
    );

    modport slave (
        input  req_valid, tau1_req, tau2_req, phi_req, trigger,
        output tau1, tau2, phi, gate_en, upd
    );
endinterface

// File: rtl/dab_mod_sequencer.sv
// DAB modulation sequencer: start-up sequencing, period-synchronous slew-limited
// application of tau1/tau2/phi targets, and safe zero/gates-off on fault or disable.
module dab_mod_sequencer #(
    parameter int W           = 9,
    parameter int TAU_STEP    = 4,
    parameter int PHI_STEP    = 4,
    parameter int TAU_MAX     = 180,
    parameter int PHI_MAX     = 90,
    parameter int ARM_PERIODS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fault_in,
    dab_mod_sequencer_if.slave    bus,
    output logic                  settled,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RAMP  = 3'd2,
        RUN   = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam int CW = (ARM_PERIODS > 1) ? $clog2(ARM_PERIODS) : 1;

    localparam logic signed [W-1:0] TAU_LO = '0;
    localparam logic signed [W-1:0] TAU_HI = W'(TAU_MAX);
    localparam logic signed [W-1:0] PHI_HI = W'(PHI_MAX);
    localparam logic signed [W-1:0] PHI_LO = W'(-PHI_MAX);
    localparam logic signed [W:0]   TSTEP  = (W+1)'(TAU_STEP);
    localparam logic signed [W:0]   PSTEP  = (W+1)'(PHI_STEP);
    localparam logic [CW-1:0]       ARM_LAST = CW'(ARM_PERIODS - 1);

    function automatic logic signed [W-1:0] clamp(
        input logic signed [W-1:0] v,
        input logic signed [W-1:0] lo,
        input logic signed [W-1:0] hi
    );
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    // Difference taken one bit wider so extreme operands cannot wrap before saturation.
    function automatic logic signed [W-1:0] slew(
        input logic signed [W-1:0] act,
        input logic signed [W-1:0] tgt,
        input logic signed [W:0]   step
    );
        logic signed [W:0] d;
        d = {tgt[W-1], tgt} - {act[W-1], act};
        if (d > step)       d = step;
        else if (d < -step) d = -step;
        return act + d[W-1:0];
    endfunction

    state_t              st_q, st_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic signed [W-1:0] tau1_q, tau2_q, phi_q;
    logic signed [W-1:0] tau1_d, tau2_d, phi_d;
    logic signed [W-1:0] tt1_q, tt2_q, tph_q;
    logic signed [W-1:0] tt1_d, tt2_d, tph_d;
    logic signed [W-1:0] s_tau1, s_tau2, s_phi;
    logic                gate_q, gate_d;
    logic                upd_q, upd_d;
    logic                settled_q, settled_d;

    assign s_tau1 = slew(tau1_q, tt1_q, TSTEP);
    assign s_tau2 = slew(tau2_q, tt2_q, TSTEP);
    assign s_phi  = slew(phi_q,  tph_q, PSTEP);

    always_comb begin
        tt1_d = tt1_q;
        tt2_d = tt2_q;
        tph_d = tph_q;
        if (bus.req_valid) begin
            tt1_d = clamp(bus.tau1_req, TAU_LO, TAU_HI);
            tt2_d = clamp(bus.tau2_req, TAU_LO, TAU_HI);
            tph_d = clamp(bus.phi_req,  PHI_LO, PHI_HI);
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        tau1_d = tau1_q;
        tau2_d = tau2_q;
        phi_d  = phi_q;
        upd_d  = 1'b0;
        case (st_q)
            IDLE: begin
                tau1_d = '0;
                tau2_d = '0;
                phi_d  = '0;
                if (enable && !fault_in) begin
                    st_d  = ARM;
                    cnt_d = '0;
                end
            end
            ARM, RAMP, RUN: begin
                if (fault_in) begin
                    st_d   = FAULT;
                    tau1_d = '0;
                    tau2_d = '0;
                    phi_d  = '0;
                end else if (!enable) begin
                    st_d   = IDLE;
                    tau1_d = '0;
                    tau2_d = '0;
                    phi_d  = '0;
                end else if (bus.trigger) begin
                    if (st_q == ARM) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == ARM_LAST) st_d = RAMP;
                    end else begin
                        // A within-step RUN update is the same as one saturated step, so
                        // RAMP and RUN share the step; only the resulting state differs.
                        tau1_d = s_tau1;
                        tau2_d = s_tau2;
                        phi_d  = s_phi;
                        upd_d  = (s_tau1 != tau1_q) || (s_tau2 != tau2_q) || (s_phi != phi_q);
                        if ((s_tau1 == tt1_q) && (s_tau2 == tt2_q) && (s_phi == tph_q))
                            st_d = RUN;
                        else
                            st_d = RAMP;
                    end
                end
            end
            FAULT: begin
                tau1_d = '0;
                tau2_d = '0;
                phi_d  = '0;
                if (!enable && !fault_in) st_d = IDLE;
            end
            default: begin
                st_d   = IDLE;
                tau1_d = '0;
                tau2_d = '0;
                phi_d  = '0;
            end
        endcase
    end

    always_comb begin
        gate_d    = (st_d == ARM) || (st_d == RAMP) || (st_d == RUN);
        settled_d = (st_d == RUN) && (tau1_d == tt1_d) && (tau2_d == tt2_d) && (phi_d == tph_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= IDLE;
            cnt_q     <= '0;
            tau1_q    <= '0;
            tau2_q    <= '0;
            phi_q     <= '0;
            tt1_q     <= '0;
            tt2_q     <= '0;
            tph_q     <= '0;
            gate_q    <= 1'b0;
            upd_q     <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            tau1_q    <= tau1_d;
            tau2_q    <= tau2_d;
            phi_q     <= phi_d;
            tt1_q     <= tt1_d;
            tt2_q     <= tt2_d;
            tph_q     <= tph_d;
            gate_q    <= gate_d;
            upd_q     <= upd_d;
            settled_q <= settled_d;
        end
    end

    assign bus.tau1    = tau1_q;
    assign bus.tau2    = tau2_q;
    assign bus.phi     = phi_q;
    assign bus.gate_en = gate_q;
    assign bus.upd     = upd_q;
    assign settled     = settled_q;
    assign state       = st_q;

endmodule

// File: tb/tb_dab_mod_sequencer.sv
// Directed bench for dab_mod_sequencer: start-up, clamping, RUN small/large steps,
// fault handling, simultaneous request/trigger and synchronous reset mid-ramp.
module tb_dab_mod_sequencer;
    localparam int W = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       fault_in;
    logic       settled;
    logic [2:0] state;
    int         checks = 0;
    int         errors = 0;

    dab_mod_sequencer_if #(.W(W)) bus ();

    dab_mod_sequencer #(
        .W(W), .TAU_STEP(4), .PHI_STEP(4), .TAU_MAX(180), .PHI_MAX(90), .ARM_PERIODS(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .fault_in(fault_in),
        .bus(bus), .settled(settled), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic trig();
        repeat (3) tick();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
    endtask

    task automatic request(input int t1, input int t2, input int ph);
        bus.req_valid = 1'b1;
        bus.tau1_req  = W'(t1);
        bus.tau2_req  = W'(t2);
        bus.phi_req   = W'(ph);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input int t1, input int t2, input int ph,
                             input int st, input int up);
        check({tag, ".tau1"},  bus.tau1, t1);
        check({tag, ".tau2"},  bus.tau2, t2);
        check({tag, ".phi"},   bus.phi,  ph);
        check({tag, ".state"}, state,    st);
        check({tag, ".upd"},   bus.upd,  up);
    endtask

    task automatic arm_sequence();
        enable = 1'b1;
        tick();
        check("arm.state", state, 1);
        check("arm.gate", bus.gate_en, 1);
        for (int k = 1; k <= 4; k++) begin
            trig();
            check_out("arm.trig", 0, 0, 0, (k == 4) ? 2 : 1, 0);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; fault_in = 1'b0;
        bus.req_valid = 1'b0; bus.trigger = 1'b0;
        bus.tau1_req = '0; bus.tau2_req = '0; bus.phi_req = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_out("reset", 0, 0, 0, 0, 0);
        check("reset.gate", bus.gate_en, 0);
        check("reset.settled", settled, 0);

        trig();
        check_out("idle_trig", 0, 0, 0, 0, 0);

        // Start-up toward 40/40/20
        request(40, 40, 20);
        arm_sequence();
        for (int k = 1; k <= 10; k++) begin
            trig();
            check_out("ramp", (4*k > 40) ? 40 : 4*k, (4*k > 40) ? 40 : 4*k,
                      (4*k > 20) ? 20 : 4*k, (k == 10) ? 3 : 2, 1);
        end
        check("run.settled", settled, 1);
        trig();
        check_out("run.idle_trig", 40, 40, 20, 3, 0);

        // RUN small step then large step
        request(40, 40, 23);
        check("small.settled_pre", settled, 0);
        trig();
        check_out("small", 40, 40, 23, 3, 1);
        check("small.settled", settled, 1);
        request(40, 40, 20);
        trig();
        check_out("back20", 40, 40, 20, 3, 1);
        request(40, 40, 40);
        trig();
        check_out("large", 40, 40, 24, 2, 1);
        for (int k = 2; k <= 5; k++) begin
            trig();
            check_out("large.ramp", 40, 40, 20 + 4*k, (k == 5) ? 3 : 2, 1);
        end
        check("large.settled", settled, 1);

        // Down to 10, then simultaneous req_valid + trigger
        request(40, 40, 10);
        for (int k = 1; k <= 8; k++) begin
            trig();
            check_out("down", 40, 40, (40 - 4*k < 10) ? 10 : 40 - 4*k, (k == 8) ? 3 : 2, 1);
        end
        repeat (3) tick();
        bus.trigger = 1'b1; bus.req_valid = 1'b1;
        bus.tau1_req = W'(40); bus.tau2_req = W'(40); bus.phi_req = W'(14);
        tick();
        bus.trigger = 1'b0; bus.req_valid = 1'b0;
        check_out("simul", 40, 40, 10, 3, 0);
        check("simul.settled", settled, 0);
        trig();
        check_out("simul.next", 40, 40, 14, 3, 1);

        // Clamp: targets become 0 / 180 / -90
        request(-5, 250, -200);
        trig();
        check_out("clamp1", 36, 44, 10, 2, 1);
        trig();
        check_out("clamp2", 32, 48, 6, 2, 1);

        // Fault mid-ramp with a coincident trigger
        repeat (2) tick();
        fault_in = 1'b1; bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        check_out("fault", 0, 0, 0, 4, 0);
        check("fault.gate", bus.gate_en, 0);
        check("fault.settled", settled, 0);
        fault_in = 1'b0;
        trig();
        check_out("fault.hold", 0, 0, 0, 4, 0);
        enable = 1'b0;
        tick();
        check("fault.exit", state, 0);

        // Restart: captured clamped targets still held
        arm_sequence();
        for (int k = 1; k <= 45; k++) begin
            trig();
            if (k == 1 || k == 23 || k == 44 || k == 45)
                check_out("clamp.ramp", 0, 4*k, (-4*k < -90) ? -90 : -4*k, (k == 45) ? 3 : 2, 1);
        end
        check("clamp.settled", settled, 1);

        // Sync reset mid-ramp with coincident trigger and request
        request(0, 180, 0);
        trig();
        check_out("pre_rst", 0, 180, -86, 2, 1);
        repeat (2) tick();
        rst = 1'b1; bus.trigger = 1'b1; bus.req_valid = 1'b1;
        bus.tau1_req = W'(50); bus.tau2_req = W'(50); bus.phi_req = W'(50);
        tick();
        rst = 1'b0; bus.trigger = 1'b0; bus.req_valid = 1'b0;
        check_out("rst_mid", 0, 0, 0, 0, 0);
        check("rst_mid.gate", bus.gate_en, 0);
        check("rst_mid.settled", settled, 0);
        tick();
        check("rst_mid.rearm", state, 1);
        for (int k = 1; k <= 4; k++) trig();
        check("rst_mid.ramp", state, 2);
        trig();
        check_out("rst_mid.zero_tgt", 0, 0, 0, 3, 0);
        check("rst_mid.settled_run", settled, 1);

        enable = 1'b0;
        tick();
        check_out("disable", 0, 0, 0, 0, 0);
        check("disable.gate", bus.gate_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 expected=1");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dab_mod_sequencer.md
Name: dab_mod_sequencer

Overview:
- Sits between the DAB controller (produces tau1/tau2/phi requests) and the DAB modulator (consumes tau1/tau2/phi and emits a period-boundary trigger).
- Sequences converter start-up: idle, gate arm, soft-ramp, run.
- Applies new modulation parameters only at switching-period boundaries, slew-limited per period.
- Forces a safe zero-modulation, gates-off state on fault or disable.

Parameters:
- W, 9, width of the signed tau1/tau2/phi words.
- TAU_STEP, 4, max |change| of tau1/tau2 per switching period.
- PHI_STEP, 4, max |change| of phi per switching period.
- TAU_MAX, 180, upper clamp for tau targets; lower clamp is 0.
- PHI_MAX, 90, symmetric clamp for phi targets, ±PHI_MAX.
- ARM_PERIODS, 4, number of triggers spent in ARM at zero modulation; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  level; converter run request
- fault_in  in  1  level; any protection fault
- trigger  in  1  one-cycle pulse from the modulator at each switching-period boundary
- req_valid  in  1  one-cycle pulse; new targets present on the *_req inputs
- tau1_req  in  W signed  requested tau1
- tau2_req  in  W signed  requested tau2
- phi_req  in  W signed  requested phi
- tau1  out  W signed  applied tau1, to the modulator
- tau2  out  W signed  applied tau2
- phi  out  W signed  applied phi
- gate_en  out  1  modulator gate enable
- upd  out  1  one-cycle pulse; applied values changed this cycle
- settled  out  1  high in RUN when applied values equal the targets
- state  out  3  state code: IDLE=0, ARM=1, RAMP=2, RUN=3, FAULT=4

Behaviour:
- Clocking: single clock `clk`; reset is synchronous and active-high on `rst`.
- Reset values: state=IDLE; tau1, tau2, phi=0; targets=0; gate_en, upd, settled=0; ARM counter=0.
- Target capture:
  - On req_valid, the *_req inputs are clamped and registered into the target registers.
  - tau is clamped to [0, TAU_MAX]; phi is clamped to [-PHI_MAX, PHI_MAX].
  - Targets are captured in every state, FAULT included.
- Slew rule, at a trigger in RAMP/RUN:
  - next = active + sat(target - active, ±STEP).
  - Difference is computed at W+1 bits; no wrap-around is permitted.
- Output timing:
  - A trigger sampled in cycle t updates the outputs in cycle t+1.
  - upd is high in t+1 only if any applied value changed.
  - If req_valid and trigger arrive in the same cycle, the slew uses the old target; the new target takes effect at the next trigger.
- FSM, evaluated in priority order each cycle:
  - rst → IDLE.
  - fault_in=1 in ARM/RAMP/RUN → FAULT.
  - enable=0 in ARM/RAMP/RUN → IDLE.
  - IDLE: outputs 0, gate_en=0. If enable=1 and fault_in=0 → ARM, counter cleared.
  - ARM: gate_en=1, tau/phi held at 0. Each trigger increments the counter. A trigger with counter=ARM_PERIODS-1 → RAMP.
  - RAMP: each trigger applies one slew step. When all three applied values equal their targets after a step → RUN.
  - RUN: settled=1 while applied==targets. At a trigger:
    - if every |target-active| ≤ its STEP, apply the target directly and stay in RUN;
    - otherwise apply one slew step and go → RAMP.
  - FAULT: gate_en=0, tau/phi=0, settled=0. Exit to IDLE only when enable=0 and fault_in=0. Applied values restart from 0 on the next start.
- Exits to IDLE or FAULT:
  - Outputs zero and gate_en clears in the cycle following the offending sample (registered).
  - No upd pulse is emitted for the zeroing.
- Reset mid-operation: rst overrides all; same-cycle trigger and req_valid are ignored.
- Trigger in IDLE or FAULT has no effect. A trigger while rst=1 has no effect.
- settled is registered and combinationally consistent with state.

Test Plan:
1. Start-up with ARM_PERIODS=4:
   - Stimulus: rst, then enable=1 with targets tau1=40, tau2=40, phi=20; triggers every 100 cycles.
   - Response: gate_en=1 one cycle after enable. After 4 triggers, state=RAMP. phi ramps 4, 8, …, 20 (5 triggers); tau reaches 40 after 10 triggers. Then state=RUN and settled=1.
2. Clamp:
   - Stimulus: req_valid with tau1_req=-5, tau2_req=250, phi_req=-200.
   - Response: targets are 0, 180 and -90; the ramp heads toward those values.
3. RUN small/large step:
   - Stimulus: in RUN at phi=20, target phi=23.
   - Response: phi=23 at the next trigger and state stays RUN.
   - Stimulus: target phi=40.
   - Response: phi=24 at the next trigger, state=RAMP, and RUN is regained at 40.
4. Fault mid-ramp:
   - Stimulus: assert fault_in during RAMP.
   - Response: next cycle state=4, gate_en=0, outputs 0, upd=0.
   - Stimulus: enable=1 held with fault cleared.
   - Response: remains in FAULT.
   - Stimulus: enable=0.
   - Response: IDLE.
5. Simultaneous req_valid+trigger:
   - Stimulus: in RUN at phi=10 with old target 10, same-cycle req_valid phi=14.
   - Response: phi stays 10 and upd=0; the next trigger gives phi=14 with upd=1.
6. Sync reset mid-RAMP:
   - Stimulus: rst=1 for 1 cycle together with a trigger.
   - Response: next cycle all outputs are 0, state=IDLE and targets are 0.
